// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: buffered TX/RX front-end for the CPLD UART on the shared RAM1 bus.
// The CPU pushes bytes into a TX FIFO and pops received bytes from an RX FIFO.
// The FSM generates the rdn/wrn strobe sequences itself and keeps RAM1 disabled.
module uart_fifo_bridge #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned TIMEOUT    = 1023
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tbre,
   input  logic                  tsre,
   input  logic                  data_ready,
   inout  wire  [7:0]            ram1_data,
   output logic                  rdn,
   output logic                  wrn,
   output logic                  ram1_oe,
   output logic                  ram1_we,
   output logic                  ram1_en,
   input  logic                  tx_wr,
   input  logic [7:0]            tx_data,
   output logic                  tx_full,
   input  logic                  rx_rd,
   output logic [7:0]            rx_data,
   output logic                  rx_empty,
   output logic [DEPTH_LOG2:0]   tx_count,
   output logic [DEPTH_LOG2:0]   rx_count,
   output logic                  tx_err,
   output logic                  rx_ovf
);

   localparam int unsigned DEPTH     = 2 ** DEPTH_LOG2;
   localparam logic [9:0]  TIMEOUT_V = 10'(TIMEOUT);

   typedef enum logic [3:0] {
      IDLE, RD_LOW, RD_SAMPLE, RD_END,
      WR_SETUP, WR_LOW, WR_HIGH, WR_WAIT_TBRE, WR_WAIT_TSRE
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic                  w_abort;
   logic [9:0]            r_timer;
   logic                  r_rdn;
   logic                  r_wrn;
   logic                  r_bus_oe;
   logic                  r_tx_err;
   logic                  r_rx_ovf;

   logic [7:0]            r_tx_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_tx_wptr;
   logic [DEPTH_LOG2-1:0] r_tx_rptr;
   logic [DEPTH_LOG2:0]   r_tx_count;
   logic [7:0]            r_rx_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_rx_wptr;
   logic [DEPTH_LOG2-1:0] r_rx_rptr;
   logic [DEPTH_LOG2:0]   r_rx_count;

   logic                  w_tx_full;
   logic                  w_tx_empty;
   logic                  w_tx_push;
   logic                  w_tx_pop;
   logic                  w_rx_full;
   logic                  w_rx_empty;
   logic                  w_rx_push;
   logic                  w_rx_pop;
   logic                  w_wait_state;

   // Occupancy reaches DEPTH only when the MSB of the count is set.
   assign w_tx_full    = r_tx_count[DEPTH_LOG2];
   assign w_tx_empty   = (r_tx_count == '0);
   assign w_rx_full    = r_rx_count[DEPTH_LOG2];
   assign w_rx_empty   = (r_rx_count == '0);
   assign w_tx_push    = tx_wr && !w_tx_full;
   assign w_tx_pop     = (r_state == WR_HIGH) && !w_tx_empty;
   assign w_rx_push    = (r_state == RD_SAMPLE) && !w_rx_full;
   assign w_rx_pop     = rx_rd && !w_rx_empty;
   assign w_wait_state = (r_state == WR_WAIT_TBRE) || (r_state == WR_WAIT_TSRE);

   assign ram1_data = r_bus_oe ? r_tx_mem[r_tx_rptr] : 'z;
   assign rdn       = r_rdn;
   assign wrn       = r_wrn;
   assign ram1_oe   = 1'b1;
   assign ram1_we   = 1'b1;
   assign ram1_en   = 1'b1;
   assign tx_full   = w_tx_full;
   assign rx_empty  = w_rx_empty;
   assign rx_data   = w_rx_empty ? '0 : r_rx_mem[r_rx_rptr];
   assign tx_count  = r_tx_count;
   assign rx_count  = r_rx_count;
   assign tx_err    = r_tx_err;
   assign rx_ovf    = r_rx_ovf;

   // FIFO storage: contents are not reset, only the pointers are.
   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wptr] <= tx_data;
      if (w_rx_push) r_rx_mem[r_rx_wptr] <= ram1_data;
   end

   // FIFO pointers and occupancy counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tx_wptr  <= '0;
         r_tx_rptr  <= '0;
         r_tx_count <= '0;
         r_rx_wptr  <= '0;
         r_rx_rptr  <= '0;
         r_rx_count <= '0;
      end else begin
         if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
         if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
         if (w_tx_push && !w_tx_pop)      r_tx_count <= r_tx_count + 1'b1;
         else if (!w_tx_push && w_tx_pop) r_tx_count <= r_tx_count - 1'b1;
         if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
         if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
         if (w_rx_push && !w_rx_pop)      r_rx_count <= r_rx_count + 1'b1;
         else if (!w_rx_push && w_rx_pop) r_rx_count <= r_rx_count - 1'b1;
      end
   end

   // Next-state logic; RX service has priority over TX in IDLE.
   always_comb begin
      w_state_next = r_state;
      w_abort      = 1'b0;
      case (r_state)
         IDLE: begin
            if (data_ready && !w_rx_full)  w_state_next = RD_LOW;
            else if (!w_tx_empty && tsre)  w_state_next = WR_SETUP;
         end
         RD_LOW:    w_state_next = RD_SAMPLE;
         RD_SAMPLE: w_state_next = RD_END;
         RD_END:    w_state_next = IDLE;
         WR_SETUP:  w_state_next = WR_LOW;
         WR_LOW:    w_state_next = WR_HIGH;
         WR_HIGH:   w_state_next = WR_WAIT_TBRE;
         WR_WAIT_TBRE: begin
            if (tbre) w_state_next = WR_WAIT_TSRE;
            else if (r_timer == TIMEOUT_V) begin
               w_state_next = IDLE;
               w_abort      = 1'b1;
            end
         end
         WR_WAIT_TSRE: begin
            if (tsre) w_state_next = IDLE;
            else if (r_timer == TIMEOUT_V) begin
               w_state_next = IDLE;
               w_abort      = 1'b1;
            end
         end
         default:   w_state_next = IDLE;
      endcase
   end

   // State, registered strobes/bus enable (decoded from next state), wait timer and sticky flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_rdn    <= 1'b1;
         r_wrn    <= 1'b1;
         r_bus_oe <= 1'b0;
         r_timer  <= '0;
         r_tx_err <= 1'b0;
         r_rx_ovf <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_rdn    <= !((w_state_next == RD_LOW) || (w_state_next == RD_SAMPLE));
         r_wrn    <= (w_state_next != WR_LOW);
         r_bus_oe <= (w_state_next == WR_SETUP) || (w_state_next == WR_LOW) ||
                     (w_state_next == WR_HIGH);
         if (w_state_next != r_state) r_timer <= '0;
         else if (w_wait_state)       r_timer <= r_timer + 1'b1;
         if (w_abort)                 r_tx_err <= 1'b1;
         if (rx_rd && w_rx_empty)     r_rx_ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb_uart_fifo_bridge: directed tests for uart_fifo_bridge with a simple CPLD bus model.
module tb_uart_fifo_bridge;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tbre = 1'b1;
   logic       tsre = 1'b1;
   logic       data_ready = 1'b0;
   logic       tx_wr = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       rx_rd = 1'b0;
   logic [7:0] r_bus_val = 8'h00;
   wire  [7:0] ram1_data;
   logic       rdn, wrn, ram1_oe, ram1_we, ram1_en;
   logic       tx_full, rx_empty, tx_err, rx_ovf;
   logic [7:0] rx_data;
   logic [4:0] tx_count, rx_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Bus monitor state
   int         rd_pulses = 0;
   int         wr_pulses = 0;
   int         rd_low_cyc = 0;
   int         overlaps = 0;
   logic       prev_rdn = 1'b1;
   logic       prev_wrn = 1'b1;
   logic [7:0] wq[$];
   int         kinds[$];

   uart_fifo_bridge #(.DEPTH_LOG2(4), .TIMEOUT(1023)) dut (
      .clk(clk), .rst(rst), .tbre(tbre), .tsre(tsre), .data_ready(data_ready),
      .ram1_data(ram1_data), .rdn(rdn), .wrn(wrn),
      .ram1_oe(ram1_oe), .ram1_we(ram1_we), .ram1_en(ram1_en),
      .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
      .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty),
      .tx_count(tx_count), .rx_count(rx_count), .tx_err(tx_err), .rx_ovf(rx_ovf)
   );

   // CPLD model returns r_bus_val while rdn is low
   assign ram1_data = (!rdn) ? r_bus_val : 8'hzz;

   always #5 clk = ~clk;

   // Record strobe pulses, written bytes and strobe overlap on the falling clock edge
   always @(negedge clk) begin
      if (!rdn && prev_rdn) begin rd_pulses++; kinds.push_back(1); end
      if (!wrn && prev_wrn) begin wr_pulses++; kinds.push_back(2); end
      if (!rdn) rd_low_cyc++;
      if (!wrn) wq.push_back(ram1_data);
      if (!rdn && !wrn) overlaps++;
      prev_rdn = rdn;
      prev_wrn = wrn;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; tbre = 1'b1; tsre = 1'b1;
      repeat (2) tick();
      n_checks++; if (rdn !== 1'b1) begin n_fail++; $display("FAIL reset_rdn: got %b want 1", rdn); end
      n_checks++; if (wrn !== 1'b1) begin n_fail++; $display("FAIL reset_wrn: got %b want 1", wrn); end
      n_checks++; if (tx_count !== 5'd0) begin n_fail++; $display("FAIL reset_tx_count: got %0d want 0", tx_count); end
      n_checks++; if (rx_count !== 5'd0) begin n_fail++; $display("FAIL reset_rx_count: got %0d want 0", rx_count); end
      n_checks++; if (tx_full !== 1'b0) begin n_fail++; $display("FAIL reset_tx_full: got %b want 0", tx_full); end
      n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL reset_rx_empty: got %b want 1", rx_empty); end
      n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
      n_checks++; if (tx_err !== 1'b0) begin n_fail++; $display("FAIL reset_tx_err: got %b want 0", tx_err); end
      n_checks++; if (rx_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ovf: got %b want 0", rx_ovf); end
      n_checks++; if ({ram1_oe, ram1_we, ram1_en} !== 3'b111) begin n_fail++; $display("FAIL reset_ram1_ctrl: got %b want 111", {ram1_oe, ram1_we, ram1_en}); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single_write();
      int wr0;
      int q0;
      wr0 = wr_pulses; q0 = wq.size();
      tx_data = 8'hA5; tx_wr = 1'b1;
      tick();  // push edge
      tx_wr = 1'b0;
      n_checks++; if (tx_count !== 5'd1) begin n_fail++; $display("FAIL wr_count_after_push: got %0d want 1", tx_count); end
      n_checks++; if (wrn !== 1'b1) begin n_fail++; $display("FAIL wr_wrn_push_cycle: got %b want 1", wrn); end
      tick();  // WR_SETUP
      n_checks++; if (wrn !== 1'b1) begin n_fail++; $display("FAIL wr_wrn_setup: got %b want 1", wrn); end
      n_checks++; if (ram1_data !== 8'hA5) begin n_fail++; $display("FAIL wr_bus_setup: got %h want a5", ram1_data); end
      tick();  // WR_LOW
      n_checks++; if (wrn !== 1'b0) begin n_fail++; $display("FAIL wr_wrn_low: got %b want 0", wrn); end
      n_checks++; if (ram1_data !== 8'hA5) begin n_fail++; $display("FAIL wr_bus_low: got %h want a5", ram1_data); end
      tick();  // WR_HIGH
      n_checks++; if (wrn !== 1'b1) begin n_fail++; $display("FAIL wr_wrn_high: got %b want 1", wrn); end
      n_checks++; if (tx_count !== 5'd1) begin n_fail++; $display("FAIL wr_count_high: got %0d want 1", tx_count); end
      tick();  // WR_WAIT_TBRE, popped
      n_checks++; if (tx_count !== 5'd0) begin n_fail++; $display("FAIL wr_count_popped: got %0d want 0", tx_count); end
      repeat (4) tick();
      n_checks++; if (wr_pulses - wr0 !== 1) begin n_fail++; $display("FAIL wr_pulse_count: got %0d want 1", wr_pulses - wr0); end
      n_checks++; if (wq.size() - q0 !== 1 || wq[q0] !== 8'hA5) begin n_fail++; $display("FAIL wr_byte: got %0d bytes want 1 byte a5", wq.size() - q0); end
   endtask

   task automatic test_single_read();
      int r0;
      int lc0;
      r0 = rd_pulses; lc0 = rd_low_cyc;
      r_bus_val = 8'h3C; data_ready = 1'b1;
      tick();  // RD_LOW
      data_ready = 1'b0;
      n_checks++; if (rdn !== 1'b0) begin n_fail++; $display("FAIL rd_rdn_low: got %b want 0", rdn); end
      tick();  // RD_SAMPLE
      n_checks++; if (rdn !== 1'b0) begin n_fail++; $display("FAIL rd_rdn_sample: got %b want 0", rdn); end
      n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL rd_empty_sample: got %b want 1", rx_empty); end
      tick();  // RD_END
      n_checks++; if (rdn !== 1'b1) begin n_fail++; $display("FAIL rd_rdn_end: got %b want 1", rdn); end
      n_checks++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL rd_rx_data: got %h want 3c", rx_data); end
      n_checks++; if (rx_empty !== 1'b0) begin n_fail++; $display("FAIL rd_rx_empty: got %b want 0", rx_empty); end
      n_checks++; if (rx_count !== 5'd1) begin n_fail++; $display("FAIL rd_rx_count: got %0d want 1", rx_count); end
      repeat (3) tick();
      n_checks++; if (rd_low_cyc - lc0 !== 2) begin n_fail++; $display("FAIL rd_low_cycles: got %0d want 2", rd_low_cyc - lc0); end
      n_checks++; if (rd_pulses - r0 !== 1) begin n_fail++; $display("FAIL rd_pulse_count: got %0d want 1", rd_pulses - r0); end
      rx_rd = 1'b1; tick(); rx_rd = 1'b0;
      n_checks++; if (rx_empty !== 1'b1 || rx_data !== 8'h00) begin n_fail++; $display("FAIL rd_pop: got empty=%b data=%h want empty=1 data=00", rx_empty, rx_data); end
      n_checks++; if (rx_ovf !== 1'b0) begin n_fail++; $display("FAIL rd_ovf_clean: got %b want 0", rx_ovf); end
   endtask

   task automatic test_fill_tx();
      int q0;
      int cyc;
      tsre = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tx_data = 8'(i); tx_wr = 1'b1;
         tick();
      end
      tx_wr = 1'b0;
      n_checks++; if (tx_count !== 5'd16) begin n_fail++; $display("FAIL fill_count: got %0d want 16", tx_count); end
      n_checks++; if (tx_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", tx_full); end
      tx_data = 8'hEE; tx_wr = 1'b1; tick(); tx_wr = 1'b0;
      n_checks++; if (tx_count !== 5'd16) begin n_fail++; $display("FAIL fill_drop17: got %0d want 16", tx_count); end
      q0 = wq.size();
      tsre = 1'b1;
      cyc = 0;
      while ((tx_count != 5'd0 || wq.size() - q0 < 16) && cyc < 300) begin tick(); cyc++; end
      repeat (4) tick();
      n_checks++; if (cyc >= 300) begin n_fail++; $display("FAIL fill_drain_timeout: got %0d cycles want <300", cyc); end
      n_checks++; if (wq.size() - q0 !== 16) begin n_fail++; $display("FAIL fill_sent_count: got %0d want 16", wq.size() - q0); end
      for (int i = 0; i < 16; i++) begin
         if (q0 + i < wq.size()) begin
            n_checks++; if (wq[q0 + i] !== 8'(i)) begin n_fail++; $display("FAIL fill_order[%0d]: got %h want %h", i, wq[q0 + i], 8'(i)); end
         end
      end
      n_checks++; if (tx_full !== 1'b0) begin n_fail++; $display("FAIL fill_full_after: got %b want 0", tx_full); end
   endtask

   task automatic test_priority();
      int k0;
      int q0;
      tsre = 1'b0;
      tx_data = 8'h77; tx_wr = 1'b1; tick(); tx_wr = 1'b0;
      k0 = kinds.size(); q0 = wq.size();
      r_bus_val = 8'h5A; data_ready = 1'b1; tsre = 1'b1;
      tick();
      data_ready = 1'b0;
      repeat (15) tick();
      n_checks++; if (kinds.size() - k0 !== 2) begin n_fail++; $display("FAIL prio_pulses: got %0d want 2", kinds.size() - k0); end
      n_checks++; if (kinds.size() < k0 + 2 || kinds[k0] !== 1 || kinds[k0 + 1] !== 2) begin n_fail++; $display("FAIL prio_order: read-then-write not observed"); end
      n_checks++; if (wq.size() <= q0 || wq[q0] !== 8'h77) begin n_fail++; $display("FAIL prio_tx_byte: got %0d bytes want byte 77", wq.size() - q0); end
      n_checks++; if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL prio_rx_data: got %h want 5a", rx_data); end
      n_checks++; if (overlaps !== 0) begin n_fail++; $display("FAIL prio_overlap: got %0d want 0", overlaps); end
      rx_rd = 1'b1; tick(); rx_rd = 1'b0;
   endtask

   task automatic test_timeout();
      int cyc;
      int q0;
      tbre = 1'b0; tsre = 1'b1;
      tx_data = 8'h81; tx_wr = 1'b1; tick(); tx_wr = 1'b0;
      cyc = 1;
      while (!tx_err && cyc < 1500) begin tick(); cyc++; end
      n_checks++; if (tx_err !== 1'b1) begin n_fail++; $display("FAIL to_err_set: got %b want 1", tx_err); end
      n_checks++; if (cyc < 1000 || cyc > 1100) begin n_fail++; $display("FAIL to_latency: got %0d cycles want 1000..1100", cyc); end
      tick();
      n_checks++; if (wrn !== 1'b1 || tx_count !== 5'd0) begin n_fail++; $display("FAIL to_idle: got wrn=%b count=%0d want 1/0", wrn, tx_count); end
      tbre = 1'b1;
      q0 = wq.size();
      tx_data = 8'h42; tx_wr = 1'b1; tick(); tx_wr = 1'b0;
      cyc = 0;
      while (wq.size() == q0 && cyc < 20) begin tick(); cyc++; end
      repeat (4) tick();
      n_checks++; if (wq.size() <= q0 || wq[q0] !== 8'h42) begin n_fail++; $display("FAIL to_next_byte: got %0d bytes want byte 42", wq.size() - q0); end
      n_checks++; if (tx_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", tx_err); end
   endtask

   task automatic test_rx_full();
      int cyc;
      int r0;
      r_bus_val = 8'hC3; data_ready = 1'b1;
      cyc = 0;
      while (rx_count != 5'd16 && cyc < 200) begin tick(); cyc++; end
      n_checks++; if (rx_count !== 5'd16) begin n_fail++; $display("FAIL rxf_count: got %0d want 16", rx_count); end
      r0 = rd_pulses;
      repeat (10) tick();
      n_checks++; if (rd_pulses - r0 !== 0) begin n_fail++; $display("FAIL rxf_no_read: got %0d pulses want 0", rd_pulses - r0); end
      n_checks++; if (rdn !== 1'b1) begin n_fail++; $display("FAIL rxf_rdn_idle: got %b want 1", rdn); end
      rx_rd = 1'b1; tick(); rx_rd = 1'b0;
      n_checks++; if (rx_count !== 5'd15) begin n_fail++; $display("FAIL rxf_pop_one: got %0d want 15", rx_count); end
      cyc = 0;
      while (rx_count != 5'd16 && cyc < 10) begin tick(); cyc++; end
      data_ready = 1'b0;
      repeat (3) tick();
      n_checks++; if (rd_pulses - r0 !== 1) begin n_fail++; $display("FAIL rxf_refill: got %0d pulses want 1", rd_pulses - r0); end
      n_checks++; if (rx_count !== 5'd16) begin n_fail++; $display("FAIL rxf_refill_count: got %0d want 16", rx_count); end
      n_checks++; if (rx_data !== 8'hC3) begin n_fail++; $display("FAIL rxf_data: got %h want c3", rx_data); end
      rx_rd = 1'b1; repeat (16) tick(); rx_rd = 1'b0;
      n_checks++; if (rx_empty !== 1'b1 || rx_ovf !== 1'b0) begin n_fail++; $display("FAIL rxf_drain: got empty=%b ovf=%b want 1/0", rx_empty, rx_ovf); end
      rx_rd = 1'b1; tick(); rx_rd = 1'b0;
      n_checks++; if (rx_ovf !== 1'b1 || rx_count !== 5'd0) begin n_fail++; $display("FAIL rxf_underflow: got ovf=%b count=%0d want 1/0", rx_ovf, rx_count); end
      tick();
      n_checks++; if (rx_ovf !== 1'b1) begin n_fail++; $display("FAIL rxf_ovf_sticky: got %b want 1", rx_ovf); end
   endtask

   task automatic test_reset_mid();
      int q0;
      tsre = 1'b1; tbre = 1'b1;
      tx_data = 8'h5E; tx_wr = 1'b1; tick(); tx_wr = 1'b0;
      tick();  // WR_SETUP
      tick();  // WR_LOW
      n_checks++; if (wrn !== 1'b0) begin n_fail++; $display("FAIL mid_wrn_low: got %b want 0", wrn); end
      #2 rst = 1'b0;
      #1;
      n_checks++; if (wrn !== 1'b1 || rdn !== 1'b1) begin n_fail++; $display("FAIL mid_strobes: got wrn=%b rdn=%b want 1/1", wrn, rdn); end
      n_checks++; if (tx_count !== 5'd0 || tx_err !== 1'b0 || rx_ovf !== 1'b0) begin n_fail++; $display("FAIL mid_state: got count=%0d err=%b ovf=%b want 0/0/0", tx_count, tx_err, rx_ovf); end
      tick();
      rst = 1'b1;
      q0 = wq.size();
      repeat (8) tick();
      n_checks++; if (wq.size() !== q0) begin n_fail++; $display("FAIL mid_discard: got %0d bytes want 0", wq.size() - q0); end
      n_checks++; if (overlaps !== 0) begin n_fail++; $display("FAIL mid_overlap: got %0d want 0", overlaps); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_single_read();
      test_fill_tx();
      test_priority();
      test_timeout();
      test_rx_full();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
